// File: rtl/axil_arbiter_2x1_pkg.sv
// rtl/axil_arbiter_2x1_pkg.sv - shared FSM encodings and response codes for the 2x1 AXI4-Lite arbiter
package axil_arbiter_2x1_pkg;

    // Transaction FSM states, shared by the write and read paths
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd2;

    // AXI response codes
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    // Index of the master that is not g
    function automatic logic other_master(input logic g);
        return ~g;
    endfunction

endpackage

// File: rtl/axil_arbiter_2x1_rr_arb2.sv
// rtl/axil_arbiter_2x1_rr_arb2.sv - two-requester round-robin grant selector
module axil_arbiter_2x1_rr_arb2
    import axil_arbiter_2x1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       owner,
    output logic       grant
);

    logic pointer;

    // After a completed transaction, priority moves to the master that did not own it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pointer <= 1'b0;
        end else if (advance) begin
            pointer <= other_master(owner);
        end
    end

    // Contested requests go to the pointer; a lone requester always wins
    always_comb begin
        grant = (req == 2'b11) ? pointer : req[1];
    end

endmodule

// File: rtl/axil_arbiter_2x1.sv
// rtl/axil_arbiter_2x1.sv - two-master AXI4-Lite arbiter with independent round-robin write and read paths
module axil_arbiter_2x1 #(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [2*AXI_ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic [1:0]                    S_AWVALID,
    output logic [1:0]                    S_AWREADY,
    input  logic [2*AXI_DATA_WIDTH-1:0]   S_WDATA,
    input  logic [2*AXI_DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic [1:0]                    S_WVALID,
    output logic [1:0]                    S_WREADY,
    output logic [3:0]                    S_BRESP,
    output logic [1:0]                    S_BVALID,
    input  logic [1:0]                    S_BREADY,
    input  logic [2*AXI_ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic [1:0]                    S_ARVALID,
    output logic [1:0]                    S_ARREADY,
    output logic [2*AXI_DATA_WIDTH-1:0]   S_RDATA,
    output logic [3:0]                    S_RRESP,
    output logic [1:0]                    S_RVALID,
    input  logic [1:0]                    S_RREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     M_AWADDR,
    output logic                          M_AWVALID,
    input  logic                          M_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]     M_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]   M_WSTRB,
    output logic                          M_WVALID,
    input  logic                          M_WREADY,
    input  logic [1:0]                    M_BRESP,
    input  logic                          M_BVALID,
    output logic                          M_BREADY,
    output logic [AXI_ADDR_WIDTH-1:0]     M_ARADDR,
    output logic                          M_ARVALID,
    input  logic                          M_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]     M_RDATA,
    input  logic [1:0]                    M_RRESP,
    input  logic                          M_RVALID,
    output logic                          M_RREADY
);
    import axil_arbiter_2x1_pkg::*;

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;

    logic [1:0] w_state;
    logic [1:0] r_state;
    logic       wg;
    logic       rg;
    logic       aw_done;
    logic       w_done;
    logic       w_grant;
    logic       r_grant;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;
    logic       ar_hs;
    logic       r_hs;

    assign aw_hs = M_AWVALID && M_AWREADY;
    assign w_hs  = M_WVALID && M_WREADY;
    assign b_hs  = M_BVALID && M_BREADY;
    assign ar_hs = M_ARVALID && M_ARREADY;
    assign r_hs  = M_RVALID && M_RREADY;

    axil_arbiter_2x1_rr_arb2 u_w_arb (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .req     (S_AWVALID),
        .advance ((w_state == ST_RESP) && b_hs),
        .owner   (wg),
        .grant   (w_grant)
    );

    axil_arbiter_2x1_rr_arb2 u_r_arb (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .req     (S_ARVALID),
        .advance ((r_state == ST_DATA) && r_hs),
        .owner   (rg),
        .grant   (r_grant)
    );

    // Write FSM: grant, collect AW and W in either order, then wait for B
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state <= ST_IDLE;
            wg      <= 1'b0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                ST_IDLE: begin
                    if (|S_AWVALID) begin
                        wg      <= w_grant;
                        w_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        w_state <= ST_RESP;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_done || aw_hs;
                        w_done  <= w_done || w_hs;
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        w_state <= ST_IDLE;
                    end
                end
                default: w_state <= ST_IDLE;
            endcase
        end
    end

    // Write path muxing: only the granted master is connected, nothing while idle
    always_comb begin
        M_AWADDR  = '0;
        M_AWVALID = 1'b0;
        M_WDATA   = '0;
        M_WSTRB   = '0;
        M_WVALID  = 1'b0;
        M_BREADY  = 1'b0;
        S_AWREADY = '0;
        S_WREADY  = '0;
        S_BVALID  = '0;
        S_BRESP   = '0;
        if (w_state == ST_ADDR) begin
            M_AWADDR      = wg ? S_AWADDR[2*AW-1:AW] : S_AWADDR[AW-1:0];
            M_WDATA       = wg ? S_WDATA[2*DW-1:DW] : S_WDATA[DW-1:0];
            M_WSTRB       = wg ? S_WSTRB[2*SW-1:SW] : S_WSTRB[SW-1:0];
            // A channel that already handshook must not accept a second beat
            M_AWVALID     = S_AWVALID[wg] && !aw_done;
            M_WVALID      = S_WVALID[wg] && !w_done;
            S_AWREADY[wg] = M_AWREADY && !aw_done;
            S_WREADY[wg]  = M_WREADY && !w_done;
        end else if (w_state == ST_RESP) begin
            S_BVALID[wg] = M_BVALID;
            M_BREADY     = S_BREADY[wg];
            if (wg) begin
                S_BRESP[3:2] = M_BRESP;
            end else begin
                S_BRESP[1:0] = M_BRESP;
            end
        end
    end

    // Read FSM: grant, forward AR, then wait for R
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= ST_IDLE;
            rg      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|S_ARVALID) begin
                        rg      <= r_grant;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Read path muxing: only the granted master is connected, nothing while idle
    always_comb begin
        M_ARADDR  = '0;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        S_ARREADY = '0;
        S_RVALID  = '0;
        S_RDATA   = '0;
        S_RRESP   = '0;
        if (r_state == ST_ADDR) begin
            M_ARADDR      = rg ? S_ARADDR[2*AW-1:AW] : S_ARADDR[AW-1:0];
            M_ARVALID     = S_ARVALID[rg];
            S_ARREADY[rg] = M_ARREADY;
        end else if (r_state == ST_DATA) begin
            S_RVALID[rg] = M_RVALID;
            M_RREADY     = S_RREADY[rg];
            if (rg) begin
                S_RDATA[2*DW-1:DW] = M_RDATA;
                S_RRESP[3:2]       = M_RRESP;
            end else begin
                S_RDATA[DW-1:0] = M_RDATA;
                S_RRESP[1:0]    = M_RRESP;
            end
        end
    end

endmodule
